// File: rtl/i2c_reg_seq.sv
// Register-access sequencer for i2c_master: expands one read/write request into
// the i2c_master command chain, supervises each command and condenses the outcome.

`ifndef I2C_MASTER_VH
`define I2C_MASTER_VH
`define C_SZ   5
`define C_STRT 5'b00001
`define C_STOP 5'b00010
`define C_WRTE 5'b00100
`define C_READ 5'b01000
`define C_NACK 5'b10000
`define S_SZ   7
`define SB_BSY 0
`define SB_DON 1
`define SB_ACK 2
`define SB_ALO 3
`define SB_BBL 4
`define SB_LRA 5
`define SB_ILL 6
`endif

module i2c_reg_seq #(
    parameter int               MAX_LEN = 4,
    parameter int               LEN_W   = 3,
    parameter int               TMO_W   = 20,
    parameter logic [TMO_W-1:0] TMO_CYC = 20'hFFFFF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req,
    output logic                 rdy,
    input  logic                 rnw,
    input  logic [6:0]           dev,
    input  logic [7:0]           rega,
    input  logic [LEN_W-1:0]     len,
    input  logic [8*MAX_LEN-1:0] wdata,
    output logic [8*MAX_LEN-1:0] rdata,
    output logic                 done,
    output logic [1:0]           err,
    output logic [`C_SZ-1:0]     m_cmd,
    output logic [7:0]           m_dat,
    output logic                 m_ws,
    input  logic [`S_SZ-1:0]     m_stat,
    input  logic [7:0]           m_dout
);

    // Step counter must reach len+2 (last READ of a maximum-length read).
    localparam int SW = LEN_W + 1;

    localparam logic [1:0] E_OK   = 2'd0;
    localparam logic [1:0] E_NACK = 2'd1;
    localparam logic [1:0] E_MST  = 2'd2;
    localparam logic [1:0] E_TMO  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_CHECK,
        ST_ABRT,
        ST_AWAIT,
        ST_FIN
    } state_t;

    state_t               state_reg, state_next;
    logic [SW-1:0]        step_reg, step_next;
    logic [TMO_W-1:0]     wdog_reg, wdog_next;
    logic [1:0]           err_reg, err_next;

    logic                 rnw_reg;
    logic [6:0]           dev_reg;
    logic [7:0]           rega_reg;
    logic [LEN_W-1:0]     len_reg;
    logic [8*MAX_LEN-1:0] wdata_reg;
    logic [7:0]           rbyte_reg [MAX_LEN];

    logic                 accept;
    logic                 rd_store;
    logic                 len_bad;
    logic                 is_last;
    logic [SW-1:0]        last_step;
    logic [SW-1:0]        wr_idx;
    logic [SW-1:0]        rd_idx;
    logic [7:0]           wr_byte;
    logic [`C_SZ-1:0]     cur_cmd;
    logic [7:0]           cur_dat;
    logic                 st_bsy, st_don, st_ack, st_err;
    logic                 cmd_done;
    logic                 tmo_hit;

    assign st_bsy   = m_stat[`SB_BSY];
    assign st_don   = m_stat[`SB_DON];
    assign st_ack   = m_stat[`SB_ACK];
    assign st_err   = m_stat[`SB_ALO] | m_stat[`SB_BBL] | m_stat[`SB_LRA] | m_stat[`SB_ILL];
    assign cmd_done = !st_bsy && st_don;
    assign tmo_hit  = (wdog_reg == TMO_CYC - TMO_W'(1));

    assign rdy      = (state_reg == ST_IDLE) && !st_bsy;
    assign len_bad  = (len == '0) || (len > LEN_W'(MAX_LEN));

    // Writes: addr, rega, len data bytes. Reads: addr, rega, re-addr, len READs.
    assign last_step = rnw_reg ? (SW'(len_reg) + SW'(2)) : (SW'(len_reg) + SW'(1));
    assign is_last   = (step_reg == last_step);
    assign wr_idx    = step_reg - SW'(2);
    assign rd_idx    = step_reg - SW'(3);

    always_comb begin
        wr_byte = 8'h00;
        for (int k = 0; k < MAX_LEN; k++) begin
            if (wr_idx == SW'(k)) begin
                wr_byte = wdata_reg[8*k +: 8];
            end
        end
    end

    always_comb begin
        cur_cmd = `C_WRTE;
        cur_dat = 8'h00;
        if (step_reg == SW'(0)) begin
            cur_cmd = `C_STRT | `C_WRTE;
            cur_dat = {dev_reg, 1'b0};
        end else if (step_reg == SW'(1)) begin
            cur_dat = rega_reg;
        end else if (!rnw_reg) begin
            cur_dat = wr_byte;
            if (is_last) begin
                cur_cmd = `C_WRTE | `C_STOP;
            end
        end else if (step_reg == SW'(2)) begin
            cur_cmd = `C_STRT | `C_WRTE;
            cur_dat = {dev_reg, 1'b1};
        end else begin
            cur_cmd = is_last ? (`C_READ | `C_NACK | `C_STOP) : `C_READ;
        end
    end

    always_comb begin
        state_next = state_reg;
        step_next  = step_reg;
        wdog_next  = wdog_reg;
        err_next   = err_reg;
        accept     = 1'b0;
        rd_store   = 1'b0;
        m_ws       = 1'b0;
        m_cmd      = '0;
        m_dat      = 8'h00;
        done       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (req && rdy) begin
                    accept    = 1'b1;
                    step_next = '0;
                    if (len_bad) begin
                        err_next   = E_MST;
                        state_next = ST_FIN;
                    end else begin
                        err_next   = E_OK;
                        state_next = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                m_ws       = 1'b1;
                m_cmd      = cur_cmd;
                m_dat      = cur_dat;
                wdog_next  = '0;
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (cmd_done) begin
                    state_next = ST_CHECK;
                end else if (tmo_hit) begin
                    err_next   = E_TMO;
                    state_next = ST_FIN;
                end else begin
                    wdog_next = wdog_reg + TMO_W'(1);
                end
            end
            ST_CHECK: begin
                // i2c_master already released the bus on arbitration/bus errors.
                if (st_err) begin
                    err_next   = E_MST;
                    state_next = ST_FIN;
                end else if (((cur_cmd & `C_WRTE) != '0) && !st_ack) begin
                    err_next   = E_NACK;
                    state_next = ST_ABRT;
                end else begin
                    rd_store = ((cur_cmd & `C_READ) != '0);
                    if (is_last) begin
                        state_next = ST_FIN;
                    end else begin
                        step_next  = step_reg + SW'(1);
                        state_next = ST_ISSUE;
                    end
                end
            end
            ST_ABRT: begin
                m_ws       = 1'b1;
                m_cmd      = `C_STOP;
                wdog_next  = '0;
                state_next = ST_AWAIT;
            end
            ST_AWAIT: begin
                // Status of the abort STOP is not reported; the NACK stands.
                if (cmd_done) begin
                    state_next = ST_FIN;
                end else if (tmo_hit) begin
                    err_next   = E_TMO;
                    state_next = ST_FIN;
                end else begin
                    wdog_next = wdog_reg + TMO_W'(1);
                end
            end
            ST_FIN: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
            step_reg  <= '0;
            wdog_reg  <= '0;
            err_reg   <= E_OK;
            rnw_reg   <= 1'b0;
            dev_reg   <= 7'h00;
            rega_reg  <= 8'h00;
            len_reg   <= '0;
            wdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            step_reg  <= step_next;
            wdog_reg  <= wdog_next;
            err_reg   <= err_next;
            if (accept) begin
                rnw_reg   <= rnw;
                dev_reg   <= dev;
                rega_reg  <= rega;
                len_reg   <= len;
                wdata_reg <= wdata;
            end
        end
    end

    for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_rbyte
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                rbyte_reg[gi] <= 8'h00;
            end else if (accept) begin
                rbyte_reg[gi] <= 8'h00;
            end else if (rd_store && (rd_idx == SW'(gi))) begin
                rbyte_reg[gi] <= m_dout;
            end
        end
        assign rdata[8*gi +: 8] = rbyte_reg[gi];
    end

    assign err = err_reg;

endmodule

// File: tb/tb_i2c_reg_seq.sv
// Directed bench for i2c_reg_seq with a small behavioural i2c_master status model.
`timescale 1ns/1ps

module tb_i2c_reg_seq;

    localparam logic [19:0] TMO = 20'd40;
    localparam logic [4:0] C_STRT = 5'h01;
    localparam logic [4:0] C_STOP = 5'h02;
    localparam logic [4:0] C_WRTE = 5'h04;
    localparam logic [4:0] C_READ = 5'h08;
    localparam logic [4:0] C_NACK = 5'h10;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req = 1'b0;
    logic        rnw = 1'b0;
    logic [6:0]  dev = 7'h00;
    logic [7:0]  rega = 8'h00;
    logic [2:0]  len = 3'd0;
    logic [31:0] wdata = 32'h0;
    logic        rdy, done, m_ws;
    logic [31:0] rdata;
    logic [1:0]  err;
    logic [4:0]  m_cmd;
    logic [7:0]  m_dat;
    logic [6:0]  m_stat;
    logic [7:0]  m_dout;

    i2c_reg_seq #(.MAX_LEN(4), .LEN_W(3), .TMO_W(20), .TMO_CYC(TMO)) dut (
        .clk(clk), .rst(rst), .req(req), .rdy(rdy), .rnw(rnw), .dev(dev),
        .rega(rega), .len(len), .wdata(wdata), .rdata(rdata), .done(done),
        .err(err), .m_cmd(m_cmd), .m_dat(m_dat), .m_ws(m_ws),
        .m_stat(m_stat), .m_dout(m_dout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- i2c_master status model ----------------
    int         nack_at = -1;
    int         alo_at  = -1;
    bit         hang    = 1'b0;
    int         rd_base = 0;
    logic [7:0] rd_val [4];
    int         ws_cnt  = 0;
    int         rd_cnt  = 0;
    logic [4:0] log_cmd [256];
    logic [7:0] log_dat [256];

    logic       bsy_m, don_m, ack_m, alo_m, cur_nack, cur_alo;
    logic [7:0] dout_m;
    int         settle_m, cnt_m;

    assign m_stat = {3'b000, alo_m, ack_m, don_m, bsy_m};
    assign m_dout = dout_m;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            bsy_m <= 1'b1; don_m <= 1'b0; ack_m <= 1'b0; alo_m <= 1'b0;
            cur_nack <= 1'b0; cur_alo <= 1'b0; dout_m <= 8'h00;
            settle_m <= 8; cnt_m <= 0;
        end else if (settle_m > 0) begin
            settle_m <= settle_m - 1;
            if (settle_m == 1) bsy_m <= 1'b0;
        end else if (m_ws) begin
            bsy_m <= 1'b1; don_m <= 1'b0; alo_m <= 1'b0; cnt_m <= 3;
            cur_nack <= (ws_cnt == nack_at);
            cur_alo  <= (ws_cnt == alo_at);
            if ((m_cmd & C_READ) != 5'h0) dout_m <= rd_val[(rd_cnt - rd_base) & 3];
        end else if (bsy_m && !hang && cnt_m > 0) begin
            cnt_m <= cnt_m - 1;
            if (cnt_m == 1) begin
                bsy_m <= 1'b0; don_m <= 1'b1; ack_m <= !cur_nack; alo_m <= cur_alo;
            end
        end
    end

    always @(posedge clk) begin
        if (m_ws) begin
            log_cmd[ws_cnt & 255] <= m_cmd;
            log_dat[ws_cnt & 255] <= m_dat;
            ws_cnt <= ws_cnt + 1;
            if ((m_cmd & C_READ) != 5'h0) rd_cnt <= rd_cnt + 1;
        end
    end

    // ---------------- checking ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_log(input string tag, input int idx, input logic [4:0] c,
                             input logic [7:0] d, input bit chk_d);
        check($sformatf("%s_cmd%0d", tag, idx), 32'(log_cmd[idx & 255]), 32'(c));
        if (chk_d) check($sformatf("%s_dat%0d", tag, idx), 32'(log_dat[idx & 255]), 32'(d));
    endtask

    task automatic send_req(input logic r, input logic [6:0] d, input logic [7:0] ra,
                            input logic [2:0] l, input logic [31:0] wd);
        int n;
        n = 0;
        while (!rdy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!rdy) check("rdy_wait", 32'(rdy), 32'd1);
        rnw = r; dev = d; rega = ra; len = l; wdata = wd; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget, output logic [1:0] e,
                             output logic [31:0] rd, output int dcyc, output int wsneg);
        bit seen;
        seen = 1'b0; e = 2'd0; rd = 32'h0; dcyc = -1; wsneg = -1;
        for (int n = 0; n < budget; n++) begin
            if (m_ws) wsneg = cyc;
            if (done) begin
                seen = 1'b1; e = err; rd = rdata; dcyc = cyc;
                break;
            end
            @(negedge clk);
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        $display("[TB] %s: err=%0d rdata=%08h done_cyc=%0d", tag, e, rd, dcyc);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0]  e;
        logic [31:0] rd;
        int dcyc, wsneg, b, c0, nrd;
        bit found;

        rd_val[0] = 8'h00; rd_val[1] = 8'h00; rd_val[2] = 8'h00; rd_val[3] = 8'h00;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ws", 32'(m_ws), 32'd0);
        check("rst_cmd", 32'(m_cmd), 32'd0);
        check("rst_dat", 32'(m_dat), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_rdy", 32'(rdy), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("settle_rdy", 32'(rdy), 32'd0);

        // Write of two bytes, all ACKed
        b = ws_cnt;
        send_req(1'b0, 7'h50, 8'h10, 3'd2, 32'h0000BEEF);
        wait_done("wr2", 200, e, rd, dcyc, wsneg);
        check("wr2_err", 32'(e), 32'd0);
        check("wr2_nws", 32'(ws_cnt - b), 32'd4);
        check_log("wr2", b + 0, C_STRT | C_WRTE, 8'hA0, 1'b1);
        check_log("wr2", b + 1, C_WRTE, 8'h10, 1'b1);
        check_log("wr2", b + 2, C_WRTE, 8'hEF, 1'b1);
        check_log("wr2", b + 3, C_WRTE | C_STOP, 8'hBE, 1'b1);

        // Read of three bytes
        rd_base = rd_cnt;
        rd_val[0] = 8'h11; rd_val[1] = 8'h22; rd_val[2] = 8'h33;
        b = ws_cnt;
        send_req(1'b1, 7'h50, 8'h20, 3'd3, 32'hFFFFFFFF);
        wait_done("rd3", 200, e, rd, dcyc, wsneg);
        check("rd3_err", 32'(e), 32'd0);
        check("rd3_rdata", rd, 32'h00332211);
        check("rd3_nws", 32'(ws_cnt - b), 32'd6);
        check_log("rd3", b + 0, C_STRT | C_WRTE, 8'hA0, 1'b1);
        check_log("rd3", b + 1, C_WRTE, 8'h20, 1'b1);
        check_log("rd3", b + 2, C_STRT | C_WRTE, 8'hA1, 1'b1);
        check_log("rd3", b + 3, C_READ, 8'h00, 1'b0);
        check_log("rd3", b + 4, C_READ, 8'h00, 1'b0);
        check_log("rd3", b + 5, C_READ | C_NACK | C_STOP, 8'h00, 1'b0);
        repeat (5) @(negedge clk);
        check("rd3_rdata_hold", rdata, 32'h00332211);

        // Slave NACKs the register byte of a write
        nack_at = ws_cnt + 1;
        b = ws_cnt;
        send_req(1'b0, 7'h50, 8'h10, 3'd2, 32'h00001234);
        wait_done("nack", 200, e, rd, dcyc, wsneg);
        nack_at = -1;
        check("nack_err", 32'(e), 32'd1);
        repeat (5) @(negedge clk);
        check("nack_nws", 32'(ws_cnt - b), 32'd3);
        check_log("nack", b + 0, C_STRT | C_WRTE, 8'hA0, 1'b1);
        check_log("nack", b + 1, C_WRTE, 8'h10, 1'b1);
        check_log("nack", b + 2, C_STOP, 8'h00, 1'b0);
        check("nack_err_hold", 32'(err), 32'd1);

        // Arbitration loss on the first command
        alo_at = ws_cnt;
        b = ws_cnt;
        send_req(1'b0, 7'h50, 8'h10, 3'd1, 32'h00000055);
        wait_done("alo", 200, e, rd, dcyc, wsneg);
        alo_at = -1;
        check("alo_err", 32'(e), 32'd2);
        repeat (5) @(negedge clk);
        check("alo_nws", 32'(ws_cnt - b), 32'd1);
        check("alo_rdy", 32'(rdy), 32'd1);

        // Command never completes: watchdog
        hang = 1'b1;
        b = ws_cnt;
        send_req(1'b0, 7'h50, 8'h10, 3'd1, 32'h00000077);
        wait_done("tmo", int'(TMO) + 100, e, rd, dcyc, wsneg);
        check("tmo_err", 32'(e), 32'd3);
        check("tmo_latency", 32'(dcyc - wsneg), 32'(TMO) + 32'd1);
        check("tmo_nws", 32'(ws_cnt - b), 32'd1);
        repeat (3) @(negedge clk);
        check("tmo_rdy_busy", 32'(rdy), 32'd0);
        hang = 1'b0;
        found = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (rdy) begin
                found = 1'b1;
                break;
            end
        end
        check("tmo_rdy_back", 32'(found), 32'd1);

        // Length beyond MAX_LEN: error without bus activity
        b = ws_cnt;
        send_req(1'b0, 7'h50, 8'h10, 3'd5, 32'h0);
        wait_done("len5", 10, e, rd, dcyc, wsneg);
        check("len5_err", 32'(e), 32'd2);
        check("len5_nws", 32'(ws_cnt - b), 32'd0);

        // Asynchronous reset during the second READ strobe
        rd_base = rd_cnt;
        rd_val[0] = 8'h5A; rd_val[1] = 8'hA5;
        send_req(1'b1, 7'h50, 8'h20, 3'd2, 32'h0);
        found = 1'b0; nrd = 0;
        for (int n = 0; n < 200; n++) begin
            if (m_ws && ((m_cmd & C_READ) != 5'h0)) begin
                nrd++;
                if (nrd == 2) begin
                    found = 1'b1;
                    break;
                end
            end
            @(negedge clk);
        end
        check("rr_found", 32'(found), 32'd1);
        check("rr_pre_rdata", rdata, 32'h0000005A);
        #1 rst = 1'b0;
        #1;
        check("rr_ws", 32'(m_ws), 32'd0);
        check("rr_cmd", 32'(m_cmd), 32'd0);
        check("rr_dat", 32'(m_dat), 32'd0);
        check("rr_done", 32'(done), 32'd0);
        check("rr_err", 32'(err), 32'd0);
        check("rr_rdata", rdata, 32'd0);
        check("rr_rdy", 32'(rdy), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        rnw = 1'b0; len = 3'd0; req = 1'b1;
        b = ws_cnt; c0 = -1; dcyc = -1; e = 2'd0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (c0 < 0 && !bsy_m) c0 = cyc;
            if (done) begin
                dcyc = cyc; e = err;
                break;
            end
        end
        req = 1'b0;
        $display("[TB] len0_after_reset: err=%0d done_cyc=%0d settle_end=%0d", e, dcyc, c0);
        check("len0_done_cyc", 32'(dcyc), 32'(c0 + 1));
        check("len0_err", 32'(e), 32'd2);
        check("len0_nws", 32'(ws_cnt - b), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
